writeback_arbiter: RTL and testbench

- Writeback-stage arbiter directly upstream of the register file. It merges two retire streams onto the single register-file write port (`RegWrite`, `FloatRegWrite`, `Write_reg`, `Write_data`).
  - The in-order integer/load pipeline has fixed priority.
  - The long-latency FPU result stream goes through a small result queue.
- It also exposes a pending-destination lookup so decode can stall on results that are still queued.

---
 rtl/writeback_arbiter.sv | 163 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - int/FPU retire merge onto the register-file write port (optional stats: WB_ARB_STATS_EN)
module writeback_arbiter #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 2,
  parameter int REG_AW   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        int_valid,
  input  logic [REG_AW-1:0]           int_rd,
  input  logic                        int_float,
  input  logic [XLEN-1:0]             int_data,
  input  logic                        fpu_valid,
  output logic                        fpu_ready,
  input  logic [REG_AW-1:0]           fpu_rd,
  input  logic                        fpu_float,
  input  logic [XLEN-1:0]             fpu_data,
  input  logic [REG_AW-1:0]           chk_rs1,
  input  logic                        chk_rs1_float,
  input  logic [REG_AW-1:0]           chk_rs2,
  input  logic                        chk_rs2_float,
  output logic                        rs1_pending,
  output logic                        rs2_pending,
  output logic                        RegWrite,
  output logic                        FloatRegWrite,
  output logic [REG_AW-1:0]           Write_reg,
  output logic [XLEN-1:0]             Write_data,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic [15:0]                 stat_fpu_stall,
  output logic [15:0]                 stat_kill
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic              q_live [FQ_DEPTH];
  logic              q_flt  [FQ_DEPTH];
  logic [REG_AW-1:0] q_rd   [FQ_DEPTH];
  logic [XLEN-1:0]   q_data [FQ_DEPTH];
  logic [PW-1:0]     head, tail;

  logic                q_empty, int_fire, pop, bypass, push, fpu_x0, push_live;
  logic [FQ_DEPTH-1:0] kill_vec;
  logic                wr_en_d, wr_flt_d;
  logic [REG_AW-1:0]   wr_reg_d;
  logic [XLEN-1:0]     wr_data_d;

  assign fpu_ready = rst && (fq_count < CW'(FQ_DEPTH));
  assign q_empty   = (fq_count == '0);
  // Integer x0 is a legal retire but must never reach the register file.
  assign int_fire  = int_valid && (int_float || (int_rd != '0));
  assign pop       = !int_valid && !q_empty;
  assign bypass    = !int_valid && q_empty && fpu_valid && fpu_ready;
  assign push      = fpu_valid && fpu_ready && !bypass;
  assign fpu_x0    = !fpu_float && (fpu_rd == '0);
  assign push_live = !fpu_x0 &&
                     !(int_fire && (fpu_float == int_float) && (fpu_rd == int_rd));

  always_comb begin
    kill_vec    = '0;
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < FQ_DEPTH; i++) begin
      kill_vec[i] = int_fire && q_live[i] && (q_flt[i] == int_float) && (q_rd[i] == int_rd);
      if (q_live[i] && (q_flt[i] == chk_rs1_float) && (q_rd[i] == chk_rs1)) rs1_pending = 1'b1;
      if (q_live[i] && (q_flt[i] == chk_rs2_float) && (q_rd[i] == chk_rs2)) rs2_pending = 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_flt_d  = 1'b0;
    wr_reg_d  = '0;
    wr_data_d = '0;
    if (int_fire) begin
      wr_en_d   = 1'b1;
      wr_flt_d  = int_float;
      wr_reg_d  = int_rd;
      wr_data_d = int_data;
    end else if (pop && q_live[head]) begin
      wr_en_d   = 1'b1;
      wr_flt_d  = q_flt[head];
      wr_reg_d  = q_rd[head];
      wr_data_d = q_data[head];
    end else if (bypass && !fpu_x0) begin
      wr_en_d   = 1'b1;
      wr_flt_d  = fpu_float;
      wr_reg_d  = fpu_rd;
      wr_data_d = fpu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite      <= 1'b0;
      FloatRegWrite <= 1'b0;
      Write_reg     <= '0;
      Write_data    <= '0;
      fq_count      <= '0;
      head          <= '0;
      tail          <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_live[i] <= 1'b0;
        q_flt[i]  <= 1'b0;
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      RegWrite      <= wr_en_d;
      FloatRegWrite <= wr_flt_d;
      Write_reg     <= wr_reg_d;
      Write_data    <= wr_data_d;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        if (kill_vec[i]) q_live[i] <= 1'b0;
      end
      // Freed slots are cleared so the pending lookup never sees stale entries.
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        q_live[tail] <= push_live;
        q_flt[tail]  <= fpu_float;
        q_rd[tail]   <= fpu_rd;
        q_data[tail] <= fpu_data;
        tail         <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   fq_count <= fq_count + 1'b1;
        2'b01:   fq_count <= fq_count - 1'b1;
        default: fq_count <= fq_count;
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  localparam int KW = $clog2(FQ_DEPTH + 2);
  logic [KW-1:0] kill_n;
  logic [16:0]   kill_sum;

  always_comb begin
    kill_n = '0;
    for (int i = 0; i < FQ_DEPTH; i++) kill_n = kill_n + KW'(kill_vec[i]);
    if (push && !push_live) kill_n = kill_n + 1'b1;
    kill_sum = {1'b0, stat_kill} + 17'(kill_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fpu_stall <= '0;
      stat_kill      <= '0;
    end else begin
      if (fpu_valid && !fpu_ready && (stat_fpu_stall != 16'hFFFF))
        stat_fpu_stall <= stat_fpu_stall + 1'b1;
      stat_kill <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`else
  assign stat_fpu_stall = 16'd0;
  assign stat_kill      = 16'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_float, fpu_valid, fpu_float;
  logic [4:0]  int_rd, fpu_rd, chk_rs1, chk_rs2;
  logic [31:0] int_data, fpu_data;
  logic        chk_rs1_float, chk_rs2_float;
  logic        fpu_ready, rs1_pending, rs2_pending, RegWrite, FloatRegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [1:0]  fq_count;
  logic [15:0] stat_fpu_stall, stat_kill;
  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.XLEN(32), .FQ_DEPTH(2), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_rd(int_rd), .int_float(int_float), .int_data(int_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_float(fpu_float),
    .fpu_data(fpu_data),
    .chk_rs1(chk_rs1), .chk_rs1_float(chk_rs1_float), .chk_rs2(chk_rs2), .chk_rs2_float(chk_rs2_float),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .RegWrite(RegWrite), .FloatRegWrite(FloatRegWrite), .Write_reg(Write_reg), .Write_data(Write_data),
    .fq_count(fq_count), .stat_fpu_stall(stat_fpu_stall), .stat_kill(stat_kill)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; int_valid = 0; int_float = 0; int_rd = 0; int_data = 0;
    fpu_valid = 0; fpu_float = 0; fpu_rd = 0; fpu_data = 0;
    chk_rs1 = 0; chk_rs1_float = 0; chk_rs2 = 0; chk_rs2_float = 0;
    cyc(); cyc();
    checks++; if (fpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b exp 0", fpu_ready); end
    rst = 1'b1;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== 39'd0) begin errors++;
      $display("FAIL reset_outputs: got %b %b %0d %h exp all 0", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", fpu_ready); end
    checks++; if (fq_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fq_count); end
  endtask

  task automatic test_int_x0();
    int_valid = 1; int_rd = 5; int_float = 0; int_data = 32'h1234;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== {1'b1, 1'b0, 5'd5, 32'h1234}) begin errors++;
      $display("FAIL int_write: got %b %b %0d %h exp 1 0 5 1234", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    int_rd = 0; int_data = 32'h5555;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== 39'd0) begin errors++;
      $display("FAIL int_x0_idle: got %b %b %0d %h exp all 0", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    int_float = 1; int_data = 32'h77;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== {1'b1, 1'b1, 5'd0, 32'h77}) begin errors++;
      $display("FAIL int_f0_write: got %b %b %0d %h exp 1 1 0 77", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    int_valid = 0; int_float = 0;
    cyc();
  endtask

  task automatic test_bypass();
    fpu_valid = 1; fpu_rd = 3; fpu_float = 1; fpu_data = 32'h3F800000;
    chk_rs1 = 3; chk_rs1_float = 1;
    cyc();
    fpu_valid = 0;
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== {1'b1, 1'b1, 5'd3, 32'h3F800000}) begin errors++;
      $display("FAIL bypass_write: got %b %b %0d %h exp 1 1 3 3f800000", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    checks++; if (fq_count !== 2'd0) begin errors++; $display("FAIL bypass_count: got %0d exp 0", fq_count); end
    checks++; if (rs1_pending !== 1'b0) begin errors++; $display("FAIL bypass_pending: got %b exp 0", rs1_pending); end
    cyc();
  endtask

  task automatic test_contention();
    int_valid = 1; int_float = 0; int_rd = 10; int_data = 32'h100;
    fpu_valid = 1; fpu_float = 1; fpu_rd = 1; fpu_data = 32'hF1;
    cyc();
    checks++; if ({Write_reg, fq_count} !== {5'd10, 2'd1}) begin errors++;
      $display("FAIL cont_c1: got reg %0d cnt %0d exp 10 1", Write_reg, fq_count); end
    int_rd = 11; fpu_rd = 2; fpu_data = 32'hF2;
    cyc();
    checks++; if ({fq_count, fpu_ready} !== {2'd2, 1'b0}) begin errors++;
      $display("FAIL cont_full: got cnt %0d ready %b exp 2 0", fq_count, fpu_ready); end
    int_rd = 12; fpu_rd = 4; fpu_data = 32'hF4;
    chk_rs1 = 1; chk_rs1_float = 1; chk_rs2 = 2; chk_rs2_float = 1;
    #1;
    checks++; if ({rs1_pending, rs2_pending} !== 2'b11) begin errors++;
      $display("FAIL cont_pending: got %b%b exp 11", rs1_pending, rs2_pending); end
    cyc();
    int_rd = 13;
    cyc();
    checks++; if ({Write_reg, fq_count} !== {5'd13, 2'd2}) begin errors++;
      $display("FAIL cont_stall: got reg %0d cnt %0d exp 13 2", Write_reg, fq_count); end
    int_valid = 0;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== {1'b1, 1'b1, 5'd1, 32'hF1}) begin errors++;
      $display("FAIL cont_pop_f1: got %b %b %0d %h exp 1 1 1 f1", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    cyc();
    fpu_valid = 0;
    checks++; if ({Write_reg, Write_data, fq_count} !== {5'd2, 32'hF2, 2'd1}) begin errors++;
      $display("FAIL cont_pop_f2: got %0d %h cnt %0d exp 2 f2 1", Write_reg, Write_data, fq_count); end
    cyc();
    checks++; if ({RegWrite, Write_reg, Write_data, fq_count} !== {1'b1, 5'd4, 32'hF4, 2'd0}) begin errors++;
      $display("FAIL cont_pop_f4: got %b %0d %h cnt %0d exp 1 4 f4 0", RegWrite, Write_reg, Write_data, fq_count); end
    cyc();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b exp 0", RegWrite); end
`ifdef WB_ARB_STATS_EN
    checks++; if (stat_fpu_stall !== 16'd3) begin errors++; $display("FAIL stat_stall: got %0d exp 3", stat_fpu_stall); end
`else
    checks++; if (stat_fpu_stall !== 16'd0) begin errors++; $display("FAIL stat_stall_off: got %0d exp 0", stat_fpu_stall); end
`endif
  endtask

  task automatic test_kill();
    int_valid = 1; int_float = 0; int_rd = 9; int_data = 32'h99;
    fpu_valid = 1; fpu_float = 1; fpu_rd = 7; fpu_data = 32'hAAAA;
    chk_rs1 = 7; chk_rs1_float = 1;
    cyc();
    fpu_valid = 0;
    checks++; if ({rs1_pending, fq_count} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL kill_before: got pend %b cnt %0d exp 1 1", rs1_pending, fq_count); end
    int_float = 1; int_rd = 7; int_data = 32'hBBBB;
    cyc();
    checks++; if ({RegWrite, FloatRegWrite, Write_reg, Write_data} !== {1'b1, 1'b1, 5'd7, 32'hBBBB}) begin errors++;
      $display("FAIL kill_int_write: got %b %b %0d %h exp 1 1 7 bbbb", RegWrite, FloatRegWrite, Write_reg, Write_data); end
    checks++; if ({rs1_pending, fq_count} !== {1'b0, 2'd1}) begin errors++;
      $display("FAIL kill_after: got pend %b cnt %0d exp 0 1", rs1_pending, fq_count); end
    int_valid = 0;
    cyc();
    checks++; if ({RegWrite, Write_data, fq_count} !== {1'b0, 32'd0, 2'd0}) begin errors++;
      $display("FAIL kill_pop_idle: got %b %h cnt %0d exp 0 0 0", RegWrite, Write_data, fq_count); end
    // same-cycle kill of an accepted FPU result, plus an FPU x0 result
    int_valid = 1; int_float = 0; int_rd = 8; int_data = 32'h8;
    fpu_valid = 1; fpu_float = 0; fpu_rd = 8; fpu_data = 32'hF8;
    chk_rs1 = 8; chk_rs1_float = 0; chk_rs2 = 0; chk_rs2_float = 0;
    cyc();
    fpu_rd = 0; fpu_data = 32'hF0;
    checks++; if ({Write_data, fq_count, rs1_pending} !== {32'h8, 2'd1, 1'b0}) begin errors++;
      $display("FAIL kill_same_cycle: got %h cnt %0d pend %b exp 8 1 0", Write_data, fq_count, rs1_pending); end
    int_rd = 9; int_data = 32'h9;
    cyc();
    fpu_valid = 0;
    checks++; if ({fq_count, rs2_pending} !== {2'd2, 1'b0}) begin errors++;
      $display("FAIL fpu_x0_dead: got cnt %0d pend %b exp 2 0", fq_count, rs2_pending); end
    int_valid = 0;
    cyc(); cyc();
    checks++; if ({RegWrite, fq_count} !== {1'b0, 2'd0}) begin errors++;
      $display("FAIL dead_drain: got %b cnt %0d exp 0 0", RegWrite, fq_count); end
  endtask

  task automatic test_mid_reset();
    int_valid = 1; int_float = 0; int_rd = 14; int_data = 32'h14;
    fpu_valid = 1; fpu_float = 1; fpu_rd = 20; fpu_data = 32'h20;
    cyc();
    fpu_rd = 21; fpu_data = 32'h21;
    cyc();
    checks++; if (fq_count !== 2'd2) begin errors++; $display("FAIL mid_fill: got %0d exp 2", fq_count); end
    int_valid = 0; fpu_valid = 0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({fq_count, fpu_ready, RegWrite} !== {2'd0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL mid_async: got cnt %0d ready %b wr %b exp 0 0 0", fq_count, fpu_ready, RegWrite); end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({RegWrite, fq_count} !== {1'b0, 2'd0}) begin errors++;
        $display("FAIL mid_no_stale[%0d]: got %b cnt %0d exp 0 0", i, RegWrite, fq_count); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_int_x0();
    test_bypass();
    test_contention();
    test_kill();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
